// File: rtl/u_utd.sv
// u_utd: 16-bit accumulator microprocessor core with a unified 4096x16
// program/data memory, registers A/B, carry/zero flags, a 12-bit PC and a
// fetch/execute controller. Each instruction takes two cycles (FETCH, EXECUTE).
//
// Ports:
//   clk          - single clock, rising edge
//   reset        - asynchronous active-high reset of the core (memory kept)
//   load_program - host write word: [31] we, [27:16] addr, [15:0] data
//   IFF          - freeze: core state holds while high
//   w_addr       - address of the memory write this cycle, else 0
//   w_data       - data of the memory write this cycle, else 0
//   busA, busB   - registers A and B
//   LP           - combinational echo of load_program
//   done         - set once HALT has executed
module u_utd (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] load_program,
  input  logic        IFF,
  output logic [11:0] w_addr,
  output logic [15:0] w_data,
  output logic [15:0] busA,
  output logic [15:0] busB,
  output logic [31:0] LP,
  output logic        done
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  // primary opcodes, IR[15:12]
  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_LDB = 4'h1;
  localparam logic [3:0] OP_STA = 4'h2;
  localparam logic [3:0] OP_STB = 4'h3;
  localparam logic [3:0] OP_JMP = 4'h4;
  localparam logic [3:0] OP_REG = 4'h7;
  localparam logic [3:0] OP_SYS = 4'hF;

  // register-group sub-opcodes, IR[11:8]
  localparam logic [3:0] RG_ADD  = 4'h1;
  localparam logic [3:0] RG_CLA  = 4'h3;
  localparam logic [3:0] RG_CLB  = 4'h4;
  localparam logic [3:0] RG_CMA  = 4'h5;
  localparam logic [3:0] RG_INCB = 4'h6;
  localparam logic [3:0] RG_DECB = 4'h7;
  localparam logic [3:0] RG_CLC  = 4'h8;
  localparam logic [3:0] RG_CLZ  = 4'h9;
  localparam logic [3:0] RG_SC   = 4'hC;
  localparam logic [3:0] RG_SZ   = 4'hD;

  localparam logic [3:0] SYS_HALT = 4'h4;

  state_t      state_q, state_d;
  logic [11:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic        c_q, c_d;
  logic        z_q, z_d;
  logic        done_q, done_d;

  logic [15:0] mem [4096];

  // host write port
  logic        host_we;
  logic [11:0] host_addr;
  logic [15:0] host_data;
  logic        unused_lp;

  assign host_we   = load_program[31];
  assign host_addr = load_program[27:16];
  assign host_data = load_program[15:0];
  assign unused_lp = ^load_program[30:28];

  // instruction fields
  logic [3:0]  opcode;
  logic [3:0]  subop;
  logic [11:0] opnd;

  assign opcode = ir_q[15:12];
  assign subop  = ir_q[11:8];
  assign opnd   = ir_q[11:0];

  // asynchronous reads: one for fetch, one for the operand
  logic [15:0] fetch_word;
  logic [15:0] opnd_word;

  assign fetch_word = mem[pc_q];
  assign opnd_word  = mem[opnd];

  // arithmetic helpers kept outside the decode so the zero test sees the
  // actual result rather than a re-read of the next-state variable
  logic [16:0] add_sum;
  logic [15:0] b_inc;
  logic [15:0] b_dec;

  assign add_sum = {1'b0, a_q} + {1'b0, b_q};
  assign b_inc   = b_q + 16'd1;
  assign b_dec   = b_q - 16'd1;

  // core store: only when EXECUTE actually advances (not frozen)
  logic        core_we;
  logic [15:0] core_wdata;

  assign core_we    = (state_q == S_EXEC) && !IFF &&
                      ((opcode == OP_STA) || (opcode == OP_STB));
  assign core_wdata = (opcode == OP_STA) ? a_q : b_q;

  // host write has priority; a colliding core store is dropped
  always_ff @(posedge clk) begin
    if (host_we)
      mem[host_addr] <= host_data;
    else if (core_we)
      mem[opnd] <= core_wdata;
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    z_d     = z_q;
    done_d  = done_q;

    if (!IFF) begin
      case (state_q)
        S_FETCH: begin
          ir_d    = fetch_word;
          pc_d    = pc_q + 12'd1;
          state_d = S_EXEC;
        end

        S_EXEC: begin
          state_d = S_FETCH;
          case (opcode)
            OP_LDA: a_d  = opnd_word;
            OP_LDB: b_d  = opnd_word;
            OP_JMP: pc_d = opnd;
            OP_REG: begin
              case (subop)
                RG_ADD:  {c_d, a_d} = add_sum;
                RG_CLA:  a_d = 16'd0;
                RG_CLB:  b_d = 16'd0;
                RG_CMA:  a_d = ~a_q;
                RG_INCB: begin
                  b_d = b_inc;
                  z_d = (b_inc == 16'd0);
                end
                RG_DECB: begin
                  b_d = b_dec;
                  z_d = (b_dec == 16'd0);
                end
                RG_CLC:  c_d = 1'b0;
                RG_CLZ:  z_d = 1'b0;
                RG_SC:   if (c_q) pc_d = pc_q + 12'd1;
                RG_SZ:   if (z_q) pc_d = pc_q + 12'd1;
                default: ;
              endcase
            end
            OP_SYS: begin
              if (subop == SYS_HALT) begin
                state_d = S_HALT;
                done_d  = 1'b1;
              end
            end
            // STA/STB act only through the memory port; rest are NOPs
            default: ;
          endcase
        end

        S_HALT: ;  // terminal until reset

        default: state_d = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      pc_q    <= 12'd0;
      ir_q    <= 16'd0;
      a_q     <= 16'd0;
      b_q     <= 16'd0;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      z_q     <= z_d;
      done_q  <= done_d;
    end
  end

  // write-activity monitor mirrors the memory port priority
  always_comb begin
    w_addr = 12'd0;
    w_data = 16'd0;
    if (host_we) begin
      w_addr = host_addr;
      w_data = host_data;
    end else if (core_we) begin
      w_addr = opnd;
      w_data = core_wdata;
    end
  end

  assign busA = a_q;
  assign busB = b_q;
  assign done = done_q;
  assign LP   = load_program;

endmodule

// File: tb/tb_u_utd.sv
module tb_u_utd;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] load_program;
  logic        IFF;
  logic [11:0] w_addr;
  logic [15:0] w_data;
  logic [15:0] busA;
  logic [15:0] busB;
  logic [31:0] LP;
  logic        done;

  int total = 0;
  int bad   = 0;

  logic [15:0] cd_prog [11] = '{16'h7400, 16'h7300, 16'h7800, 16'h7900,
                                16'h1103, 16'h7100, 16'h7700, 16'h7100,
                                16'h7D00, 16'h4006, 16'hF400};

  u_utd dut (
    .clk          (clk),
    .reset        (reset),
    .load_program (load_program),
    .IFF          (IFF),
    .w_addr       (w_addr),
    .w_data       (w_data),
    .busA         (busA),
    .busB         (busB),
    .LP           (LP),
    .done         (done)
  );

  always #5 clk = ~clk;

  // all stimulus changes happen 1 time unit after a rising edge
  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic host_wr(input logic [11:0] a, input logic [15:0] d);
    load_program = {1'b1, 3'b000, a, d};
    run(1);
    load_program = 32'd0;
  endtask

  task automatic load_countdown();
    host_wr(12'h103, 16'h0003);
    for (int i = 0; i < 11; i++) host_wr(12'(i), cd_prog[i]);
  endtask

  task automatic test_reset();
    logic [31:0] lw;
    reset = 1'b1;
    IFF = 1'b0;
    load_program = 32'd0;
    #1;
    total++;
    if (busA !== 16'd0 || busB !== 16'd0 || done !== 1'b0) begin
      bad++;
      $display("FAIL reset_state got A=%h B=%h done=%b exp 0 0 0", busA, busB, done);
    end
    for (int i = -1; i < 11; i++) begin
      // the data word uses the ignored bits [30:28] to show they do nothing
      lw = (i < 0) ? {1'b1, 3'b111, 12'h103, 16'h0003}
                   : {1'b1, 3'b000, 12'(i), cd_prog[i]};
      load_program = lw;
      #1;
      total++;
      if (LP !== lw) begin
        bad++;
        $display("FAIL reset_lp got=%h exp=%h", LP, lw);
      end
      total++;
      if (w_addr !== lw[27:16] || w_data !== lw[15:0]) begin
        bad++;
        $display("FAIL reset_hostw got=%h/%h exp=%h/%h", w_addr, w_data, lw[27:16], lw[15:0]);
      end
      run(1);
      total++;
      if (busA !== 16'd0 || busB !== 16'd0 || done !== 1'b0) begin
        bad++;
        $display("FAIL reset_hold got A=%h B=%h done=%b exp 0 0 0", busA, busB, done);
      end
    end
    load_program = 32'd0;
    #1;
    total++;
    if (LP !== 32'd0 || w_addr !== 12'd0 || w_data !== 16'd0) begin
      bad++;
      $display("FAIL reset_idle got LP=%h wa=%h wd=%h exp 0", LP, w_addr, w_data);
    end
  endtask

  task automatic test_countdown();
    reset = 1'b0;
    run(35);
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL cd_early got done=%b exp 0", done);
    end
    run(1);
    total++;
    if (done !== 1'b1 || busA !== 16'h0006 || busB !== 16'h0000) begin
      bad++;
      $display("FAIL cd_final got done=%b A=%h B=%h exp 1 0006 0000", done, busA, busB);
    end
    run(3);
    total++;
    if (done !== 1'b1 || busA !== 16'h0006 || busB !== 16'h0000) begin
      bad++;
      $display("FAIL cd_halted got done=%b A=%h B=%h exp 1 0006 0000", done, busA, busB);
    end
  endtask

  task automatic test_carry();
    // ADD sets carry, SC skips the HALT, CLB then runs
    reset = 1'b1;
    host_wr(12'h200, 16'hFFFF);
    host_wr(12'h201, 16'h0001);
    host_wr(12'h000, 16'h0200);
    host_wr(12'h001, 16'h1201);
    host_wr(12'h002, 16'h7100);
    host_wr(12'h003, 16'h7C00);
    host_wr(12'h004, 16'hF400);
    host_wr(12'h005, 16'h7400);
    host_wr(12'h006, 16'hF400);
    reset = 1'b0;
    run(6);
    total++;
    if (busA !== 16'h0000 || busB !== 16'h0001) begin
      bad++;
      $display("FAIL carry_add got A=%h B=%h exp 0000 0001", busA, busB);
    end
    run(5);
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL carry_skip_early got done=%b exp 0", done);
    end
    run(1);
    total++;
    if (done !== 1'b1 || busA !== 16'h0000 || busB !== 16'h0000) begin
      bad++;
      $display("FAIL carry_skip got done=%b A=%h B=%h exp 1 0000 0000", done, busA, busB);
    end

    // same with CLC before SC: no skip, first HALT stops with B=1
    reset = 1'b1;
    host_wr(12'h003, 16'h7800);
    host_wr(12'h004, 16'h7C00);
    host_wr(12'h005, 16'hF400);
    host_wr(12'h006, 16'h7400);
    host_wr(12'h007, 16'hF400);
    reset = 1'b0;
    run(11);
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL clc_early got done=%b exp 0", done);
    end
    run(1);
    total++;
    if (done !== 1'b1 || busA !== 16'h0000 || busB !== 16'h0001) begin
      bad++;
      $display("FAIL clc_noskip got done=%b A=%h B=%h exp 1 0000 0001", done, busA, busB);
    end
  endtask

  task automatic test_wrap();
    reset = 1'b1;
    host_wr(12'h205, 16'h1234);
    host_wr(12'h300, 16'h0000);
    host_wr(12'h000, 16'h7400);  // CLB
    host_wr(12'h001, 16'h7700);  // DECB
    host_wr(12'h002, 16'h7D00);  // SZ  (Z=0, no skip)
    host_wr(12'h003, 16'h7600);  // INCB
    host_wr(12'h004, 16'h7D00);  // SZ  (Z=1, skip)
    host_wr(12'h005, 16'hF400);  // HALT (skipped)
    host_wr(12'h006, 16'h0205);  // LDA 205
    host_wr(12'h007, 16'h2300);  // STA 300
    host_wr(12'h008, 16'h1300);  // LDB 300
    host_wr(12'h009, 16'hF400);  // HALT
    reset = 1'b0;
    run(4);
    total++;
    if (busB !== 16'hFFFF) begin
      bad++;
      $display("FAIL wrap_decb got B=%h exp ffff", busB);
    end
    run(4);
    total++;
    if (busB !== 16'h0000 || done !== 1'b0) begin
      bad++;
      $display("FAIL wrap_incb got B=%h done=%b exp 0000 0", busB, done);
    end
    run(4);
    total++;
    if (busA !== 16'h1234 || w_addr !== 12'h000 || w_data !== 16'h0000) begin
      bad++;
      $display("FAIL sta_before got A=%h wa=%h wd=%h exp 1234 000 0000", busA, w_addr, w_data);
    end
    run(1);
    total++;
    if (w_addr !== 12'h300 || w_data !== 16'h1234) begin
      bad++;
      $display("FAIL sta_write got wa=%h wd=%h exp 300 1234", w_addr, w_data);
    end
    run(1);
    total++;
    if (w_addr !== 12'h000 || w_data !== 16'h0000) begin
      bad++;
      $display("FAIL sta_after got wa=%h wd=%h exp 000 0000", w_addr, w_data);
    end
    run(3);
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL wrap_early got done=%b exp 0", done);
    end
    run(1);
    total++;
    if (done !== 1'b1 || busA !== 16'h1234 || busB !== 16'h1234) begin
      bad++;
      $display("FAIL ldb_back got done=%b A=%h B=%h exp 1 1234 1234", done, busA, busB);
    end
  endtask

  task automatic test_iff();
    reset = 1'b1;
    load_countdown();
    reset = 1'b0;
    run(12);
    total++;
    if (busA !== 16'h0003 || busB !== 16'h0003) begin
      bad++;
      $display("FAIL iff_pre got A=%h B=%h exp 0003 0003", busA, busB);
    end
    IFF = 1'b1;
    for (int i = 0; i < 10; i++) begin
      run(1);
      total++;
      if (busA !== 16'h0003 || busB !== 16'h0003 || done !== 1'b0) begin
        bad++;
        $display("FAIL iff_frozen cyc=%0d got A=%h B=%h done=%b exp 0003 0003 0", i, busA, busB, done);
      end
    end
    IFF = 1'b0;
    run(23);
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL iff_early got done=%b exp 0", done);
    end
    run(1);
    total++;
    if (done !== 1'b1 || busA !== 16'h0006 || busB !== 16'h0000) begin
      bad++;
      $display("FAIL iff_final got done=%b A=%h B=%h exp 1 0006 0000", done, busA, busB);
    end
  endtask

  task automatic test_midreset();
    // restart from the halted countdown; program stays in memory
    reset = 1'b1;
    run(1);
    reset = 1'b0;
    run(15);
    total++;
    if (busA !== 16'h0003 || busB !== 16'h0002) begin
      bad++;
      $display("FAIL mid_pre got A=%h B=%h exp 0003 0002", busA, busB);
    end
    #1;
    reset = 1'b1;
    #1;
    total++;
    if (busA !== 16'h0000 || busB !== 16'h0000 || done !== 1'b0) begin
      bad++;
      $display("FAIL mid_clear got A=%h B=%h done=%b exp 0 0 0", busA, busB, done);
    end
    #2;
    reset = 1'b0;
    run(35);
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL mid_early got done=%b exp 0", done);
    end
    run(1);
    total++;
    if (done !== 1'b1 || busA !== 16'h0006 || busB !== 16'h0000) begin
      bad++;
      $display("FAIL mid_rerun got done=%b A=%h B=%h exp 1 0006 0000", done, busA, busB);
    end
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_carry();
    test_wrap();
    test_iff();
    test_midreset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
